eth_receive_seq: RTL and testbench

- Receive-side sequencer for the KSZ8851 16-bit host bus interface; mirror of the transmit sequencer.
- Drives the same register-access engine (NewCommand/WR/offset/length/writeData in, readData/state back).
- Polls ISR, drains every pending RXQ frame via QMU DMA, streams payload words to the FPGA fabric, and discards bad frames.

---
 rtl/eth_receive_seq.sv | 251 +++++++++++++++++++++++++
 tb/tb_eth_receive_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_receive_seq.sv
// Receive sequencer for the KSZ8851 host bus: polls ISR, drains RXQ frames through
// QMU DMA bursts on the shared register-access engine, and streams payload words out.
module eth_receive_seq #(
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        clk40m,
    input  logic        reset,
    input  logic        recvEn,
    input  logic [3:0]  state,
    input  logic [15:0] readData,
    output logic [7:0]  offset,
    output logic        length,
    output logic        WR,
    output logic [15:0] writeData,
    output logic        NewCommand,
    output logic        Dummy_Read,
    output logic [15:0] rxData,
    output logic        rxValid,
    output logic        rxSof,
    output logic        rxEof,
    output logic [11:0] rxFrameLen,
    output logic [7:0]  rxDropCnt,
    output logic [1:0]  recvStatus
);

    localparam logic [3:0] ENG_READ1  = 4'd4;
    localparam logic [3:0] ENG_READ2  = 4'd5;
    localparam logic [3:0] ENG_WRITE1 = 4'd7;
    localparam logic [3:0] ENG_WAIT   = 4'd9;

    localparam logic [7:0] REG_FHSR  = 8'h7C;
    localparam logic [7:0] REG_FHBCR = 8'h7E;
    localparam logic [7:0] REG_RXQCR = 8'h82;
    localparam logic [7:0] REG_FDPR  = 8'h86;
    localparam logic [7:0] REG_ISR   = 8'h92;
    localparam logic [7:0] REG_FCTR  = 8'h9C;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ISR, S_CLR_ISR, S_RD_FCTR, S_RD_FHSR, S_RD_FHBCR, S_SET_FDPR,
        S_SDA_R, S_SDA_W, S_BURST, S_SDA_CLR_R, S_SDA_CLR_W, S_DROP_R, S_DROP_W, S_DONE
    } fsm_t;

    fsm_t        r_fsm;
    logic [3:0]  r_prevState;
    logic [7:0]  r_frameCnt;
    logic [10:0] r_wordCnt;
    logic        r_fhsrOk;
    logic        r_fhsrCrc;
    logic [1:0]  r_skip;
    logic        r_first;
    logic [7:0]  r_offset;
    logic        r_length;
    logic        r_WR;
    logic [15:0] r_wdata;
    logic        r_NewCommand;
    logic        r_Dummy_Read;
    logic [15:0] r_rxData;
    logic        r_rxValid;
    logic        r_rxSof;
    logic        r_rxEof;
    logic [11:0] r_rxFrameLen;
    logic [7:0]  r_rxDropCnt;
    logic [1:0]  r_recvStatus;

    logic        w_done;
    logic [11:0] w_len;
    logic [12:0] w_len3;
    logic [12:0] w_words;
    logic        w_bad;

    // An access is complete when the engine comes back to Wait from Read1/Write1.
    assign w_done  = ((r_prevState == ENG_READ1) || (r_prevState == ENG_WRITE1)) && (state == ENG_WAIT);
    assign w_len   = readData[11:0];
    assign w_len3  = {1'b0, w_len} + 13'd3;
    assign w_words = (w_len3 & ~13'd3) >> 1;
    assign w_bad   = !r_fhsrOk || r_fhsrCrc || (w_len < 12'd4) || ({1'b0, w_len} > 13'(MAX_FRAME_LEN));

    assign offset     = r_offset;
    assign length     = r_length;
    assign WR         = r_WR;
    assign writeData  = r_WR ? r_wdata : 16'hzzzz;
    assign NewCommand = r_NewCommand;
    assign Dummy_Read = r_Dummy_Read;
    assign rxData     = r_rxData;
    assign rxValid    = r_rxValid;
    assign rxSof      = r_rxSof;
    assign rxEof      = r_rxEof;
    assign rxFrameLen = r_rxFrameLen;
    assign rxDropCnt  = r_rxDropCnt;
    assign recvStatus = r_recvStatus;

    always_ff @(posedge clk40m or negedge reset) begin
        if (!reset) begin
            r_fsm        <= S_IDLE;
            r_prevState  <= 4'd0;
            r_frameCnt   <= 8'd0;
            r_wordCnt    <= 11'd0;
            r_fhsrOk     <= 1'b0;
            r_fhsrCrc    <= 1'b0;
            r_skip       <= 2'd0;
            r_first      <= 1'b0;
            r_offset     <= 8'd0;
            r_length     <= 1'b0;
            r_WR         <= 1'b0;
            r_wdata      <= 16'd0;
            r_NewCommand <= 1'b0;
            r_Dummy_Read <= 1'b0;
            r_rxData     <= 16'd0;
            r_rxValid    <= 1'b0;
            r_rxSof      <= 1'b0;
            r_rxEof      <= 1'b0;
            r_rxFrameLen <= 12'd0;
            r_rxDropCnt  <= 8'd0;
            r_recvStatus <= 2'b00;
        end else begin
            r_prevState <= state;
            r_length    <= 1'b1;
            r_rxValid   <= 1'b0;
            r_rxSof     <= 1'b0;
            r_rxEof     <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    r_recvStatus <= 2'b00;
                    if (recvEn) begin
                        r_recvStatus <= 2'b01;
                        r_fsm        <= S_RD_ISR;
                        r_NewCommand <= 1'b1;
                        r_WR         <= 1'b0;
                        r_offset     <= REG_ISR;
                    end
                end
                S_RD_ISR: if (w_done) begin
                    if (!readData[13]) begin
                        r_fsm        <= S_DONE;
                        r_NewCommand <= 1'b0;
                        r_recvStatus <= 2'b10;
                    end else begin
                        r_fsm   <= S_CLR_ISR;
                        r_WR    <= 1'b1;
                        r_wdata <= 16'h2000;
                    end
                end
                S_CLR_ISR: if (w_done) begin
                    r_fsm    <= S_RD_FCTR;
                    r_WR     <= 1'b0;
                    r_offset <= REG_FCTR;
                end
                S_RD_FCTR: if (w_done) begin
                    r_frameCnt <= readData[15:8];
                    if (readData[15:8] == 8'd0) begin
                        r_fsm        <= S_DONE;
                        r_NewCommand <= 1'b0;
                        r_recvStatus <= 2'b10;
                    end else begin
                        r_fsm    <= S_RD_FHSR;
                        r_offset <= REG_FHSR;
                    end
                end
                S_RD_FHSR: if (w_done) begin
                    r_fhsrOk  <= readData[15];
                    r_fhsrCrc <= readData[0];
                    r_fsm     <= S_RD_FHBCR;
                    r_offset  <= REG_FHBCR;
                end
                S_RD_FHBCR: if (w_done) begin
                    r_rxFrameLen <= w_len;
                    r_wordCnt    <= 11'(w_words);
                    if (w_bad) begin
                        r_fsm    <= S_DROP_R;
                        r_offset <= REG_RXQCR;
                    end else begin
                        r_fsm    <= S_SET_FDPR;
                        r_WR     <= 1'b1;
                        r_offset <= REG_FDPR;
                        r_wdata  <= 16'h4000;
                    end
                end
                S_SET_FDPR: if (w_done) begin
                    r_fsm    <= S_SDA_R;
                    r_WR     <= 1'b0;
                    r_offset <= REG_RXQCR;
                end
                S_SDA_R: if (w_done) begin
                    r_fsm   <= S_SDA_W;
                    r_WR    <= 1'b1;
                    r_wdata <= readData | 16'h0008;
                end
                S_SDA_W: if (w_done) begin
                    r_fsm        <= S_BURST;
                    r_WR         <= 1'b0;
                    r_Dummy_Read <= 1'b1;
                    r_skip       <= 2'd0;
                    r_first      <= 1'b1;
                end
                // Burst words arrive one per Read2 cycle; dummy, status and byte count lead.
                S_BURST: if (state == ENG_READ2) begin
                    if (r_skip != 2'd3) begin
                        r_skip <= r_skip + 2'd1;
                    end else begin
                        r_rxData  <= readData;
                        r_rxValid <= 1'b1;
                        r_rxSof   <= r_first;
                        r_rxEof   <= (r_wordCnt == 11'd1);
                        r_first   <= 1'b0;
                        r_wordCnt <= r_wordCnt - 11'd1;
                        if (r_wordCnt == 11'd1) begin
                            r_Dummy_Read <= 1'b0;
                            r_fsm        <= S_SDA_CLR_R;
                            r_offset     <= REG_RXQCR;
                        end
                    end
                end
                S_SDA_CLR_R: if (w_done) begin
                    r_fsm   <= S_SDA_CLR_W;
                    r_WR    <= 1'b1;
                    r_wdata <= readData & ~16'h0008;
                end
                S_DROP_R: if (w_done) begin
                    r_fsm   <= S_DROP_W;
                    r_WR    <= 1'b1;
                    r_wdata <= readData | 16'h0001;
                end
                S_SDA_CLR_W, S_DROP_W: if (w_done) begin
                    if ((r_fsm == S_DROP_W) && (r_rxDropCnt != 8'hFF))
                        r_rxDropCnt <= r_rxDropCnt + 8'd1;
                    r_frameCnt <= r_frameCnt - 8'd1;
                    r_WR       <= 1'b0;
                    if (r_frameCnt == 8'd1) begin
                        r_fsm        <= S_DONE;
                        r_NewCommand <= 1'b0;
                        r_recvStatus <= 2'b10;
                    end else begin
                        r_fsm    <= S_RD_FHSR;
                        r_offset <= REG_FHSR;
                    end
                end
                S_DONE: begin
                    r_NewCommand <= 1'b0;
                    r_WR         <= 1'b0;
                    r_recvStatus <= 2'b10;
                    if (!recvEn) begin
                        r_fsm        <= S_IDLE;
                        r_recvStatus <= 2'b00;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_receive_seq.sv
// Bench for eth_receive_seq: behavioural register-access engine plus scoreboards for
// expected bus accesses and expected payload words.
module tb_eth_receive_seq;
    localparam int MAXLEN = 1518;

    logic        clk40m = 1'b0;
    logic        reset = 1'b0;
    logic        recvEn = 1'b0;
    logic [3:0]  state = 4'd9;
    logic [15:0] readData = 16'h0000;
    wire  [7:0]  offset;
    wire         length;
    wire         WR;
    wire  [15:0] writeData;
    wire         NewCommand;
    wire         Dummy_Read;
    wire  [15:0] rxData;
    wire         rxValid;
    wire         rxSof;
    wire         rxEof;
    wire  [11:0] rxFrameLen;
    wire  [7:0]  rxDropCnt;
    wire  [1:0]  recvStatus;

    eth_receive_seq #(.MAX_FRAME_LEN(MAXLEN)) dut (
        .clk40m(clk40m), .reset(reset), .recvEn(recvEn), .state(state), .readData(readData),
        .offset(offset), .length(length), .WR(WR), .writeData(writeData),
        .NewCommand(NewCommand), .Dummy_Read(Dummy_Read), .rxData(rxData), .rxValid(rxValid),
        .rxSof(rxSof), .rxEof(rxEof), .rxFrameLen(rxFrameLen), .rxDropCnt(rxDropCnt),
        .recvStatus(recvStatus)
    );

    always #5 clk40m = ~clk40m;

    typedef struct {
        logic        wr;
        logic [7:0]  off;
        logic [15:0] wd;
        logic [15:0] rd;
    } acc_t;

    typedef struct {
        logic [15:0] d;
        logic        sof;
        logic        eof;
        logic [11:0] flen;
    } rx_t;

    acc_t        accq[$];
    rx_t         rxq[$];
    logic [15:0] burstq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int rx_cnt = 0;
    int dr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pop_burst();
        if (burstq.size() != 0) return burstq.pop_front();
        return 16'h0000;
    endfunction

    // Engine: Wait -> Addr0 -> Read1/Write1 -> Wait; Read2 stream while Dummy_Read is high.
    acc_t cur;
    logic cool = 1'b0;
    always @(negedge clk40m) begin
        if (!reset) begin
            state    = 4'd9;
            cool     = 1'b0;
            readData = 16'h0000;
        end else begin
            case (state)
                4'd9: begin
                    if (cool) cool = 1'b0;
                    else if (NewCommand) begin
                        if (Dummy_Read) begin
                            state    = 4'd5;
                            readData = pop_burst();
                        end else begin
                            if (accq.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL acc_unexpected: got WR=%0b offset=%0h, expected no access", WR, offset);
                                cur.wr = WR;
                                cur.rd = 16'h0000;
                            end else begin
                                cur = accq.pop_front();
                                check("acc_wr", {31'd0, WR}, {31'd0, cur.wr});
                                check("acc_offset", {24'd0, offset}, {24'd0, cur.off});
                                check("acc_length", {31'd0, length}, 32'd1);
                                if (cur.wr) check("acc_wdata", {16'd0, writeData}, {16'd0, cur.wd});
                            end
                            state = 4'd0;
                        end
                    end
                end
                4'd0: state = cur.wr ? 4'd7 : 4'd4;
                4'd4: begin
                    state    = 4'd9;
                    readData = cur.rd;
                    cool     = 1'b1;
                end
                4'd7: begin
                    state = 4'd9;
                    cool  = 1'b1;
                end
                4'd5: begin
                    if (Dummy_Read) readData = pop_burst();
                    else begin
                        state = 4'd9;
                        cool  = 1'b1;
                    end
                end
                default: state = 4'd9;
            endcase
        end
    end

    // Payload monitor
    always @(negedge clk40m) begin
        if (reset && Dummy_Read) dr_cnt++;
        if (reset && rxValid) begin
            rx_t e;
            rx_cnt++;
            if (rxq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got rxData=%0h, expected no rxValid", rxData);
            end else begin
                e = rxq.pop_front();
                check("rx_data", {16'd0, rxData}, {16'd0, e.d});
                check("rx_sof", {31'd0, rxSof}, {31'd0, e.sof});
                check("rx_eof", {31'd0, rxEof}, {31'd0, e.eof});
                check("rx_framelen", {20'd0, rxFrameLen}, {20'd0, e.flen});
            end
        end
    end

    task automatic push_acc(input logic wr, input logic [7:0] off, input logic [15:0] wd, input logic [15:0] rd);
        acc_t a;
        a.wr = wr;
        a.off = off;
        a.wd = wd;
        a.rd = rd;
        accq.push_back(a);
    endtask

    task automatic push_head(input logic [15:0] fctr);
        push_acc(1'b0, 8'h92, 16'h0000, 16'h2000);
        push_acc(1'b1, 8'h92, 16'h2000, 16'h0000);
        push_acc(1'b0, 8'h9C, 16'h0000, fctr);
    endtask

    task automatic push_frame(input logic [15:0] fhsr, input logic [11:0] len);
        int  nw;
        bit  good;
        rx_t r;
        good = fhsr[15] && !fhsr[0] && (len >= 12'd4) && (int'(len) <= MAXLEN);
        push_acc(1'b0, 8'h7C, 16'h0000, fhsr);
        push_acc(1'b0, 8'h7E, 16'h0000, {4'h0, len});
        if (good) begin
            push_acc(1'b1, 8'h86, 16'h4000, 16'h0000);
            push_acc(1'b0, 8'h82, 16'h0000, 16'h0030);
            push_acc(1'b1, 8'h82, 16'h0038, 16'h0000);
            burstq.push_back(16'hD0D0);
            burstq.push_back(fhsr);
            burstq.push_back({4'h0, len});
            nw = ((int'(len) + 3) / 4) * 2;
            for (int i = 0; i < nw; i++) begin
                r.d    = {len[7:0], 8'(i)};
                r.sof  = (i == 0);
                r.eof  = (i == nw - 1);
                r.flen = len;
                burstq.push_back(r.d);
                rxq.push_back(r);
            end
            push_acc(1'b0, 8'h82, 16'h0000, 16'h0038);
            push_acc(1'b1, 8'h82, 16'h0030, 16'h0000);
        end else begin
            push_acc(1'b0, 8'h82, 16'h0000, 16'h0030);
            push_acc(1'b1, 8'h82, 16'h0031, 16'h0000);
        end
    endtask

    task automatic run_pass(input string name);
        bit seen;
        recvEn = 1'b1;
        @(negedge clk40m);
        check({name, "_busy"}, {30'd0, recvStatus}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk40m);
            if (recvStatus == 2'b10) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done"}, {31'd0, seen}, 32'd1);
        recvEn = 1'b0;
        @(negedge clk40m);
        check({name, "_idle"}, {30'd0, recvStatus}, 32'd0);
        check({name, "_acc_left"}, accq.size(), 32'd0);
        check({name, "_rx_left"}, rxq.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_newcmd"}, {31'd0, NewCommand}, 32'd0);
        check({name, "_dummy"}, {31'd0, Dummy_Read}, 32'd0);
        check({name, "_wr"}, {31'd0, WR}, 32'd0);
        check({name, "_offset"}, {24'd0, offset}, 32'd0);
        check({name, "_length"}, {31'd0, length}, 32'd0);
        check({name, "_rxvalid"}, {29'd0, rxValid, rxSof, rxEof}, 32'd0);
        check({name, "_rxdata"}, {16'd0, rxData}, 32'd0);
        check({name, "_framelen"}, {20'd0, rxFrameLen}, 32'd0);
        check({name, "_dropcnt"}, {24'd0, rxDropCnt}, 32'd0);
        check({name, "_status"}, {30'd0, recvStatus}, 32'd0);
        check({name, "_wdata_z"}, {31'd0, (writeData === 16'hzzzz) || (writeData === 16'h0000)}, 32'd1);
    endtask

    initial begin
        int base;
        int dbase;
        bit hit;

        repeat (3) @(negedge clk40m);
        check_reset_outputs("rst");
        reset = 1'b1;
        @(negedge clk40m);

        // No RX interrupt pending: a single ISR read, then done
        base = rx_cnt;
        push_acc(1'b0, 8'h92, 16'h0000, 16'h0000);
        run_pass("isr0");
        check("isr0_rxvalid", rx_cnt - base, 32'd0);

        // One 64-byte frame
        base = rx_cnt;
        push_head(16'h0100);
        push_frame(16'h8000, 12'd64);
        run_pass("len64");
        check("len64_words", rx_cnt - base, 32'd32);
        check("len64_framelen", {20'd0, rxFrameLen}, 32'd64);
        check("len64_dropcnt", {24'd0, rxDropCnt}, 32'd0);

        // 61 bytes rounds up to 32 words
        base = rx_cnt;
        push_head(16'h0100);
        push_frame(16'h8000, 12'd61);
        run_pass("len61");
        check("len61_words", rx_cnt - base, 32'd32);
        check("len61_framelen", {20'd0, rxFrameLen}, 32'd61);

        // Three frames, the middle one with a CRC error
        base = rx_cnt;
        push_head(16'h0300);
        push_frame(16'h8000, 12'd8);
        push_frame(16'h8001, 12'd20);
        push_frame(16'h8000, 12'd6);
        run_pass("crc");
        check("crc_words", rx_cnt - base, 32'd8);
        check("crc_dropcnt", {24'd0, rxDropCnt}, 32'd1);

        // Oversize frame is released without DMA
        base  = rx_cnt;
        dbase = dr_cnt;
        push_head(16'h0100);
        push_frame(16'h8000, 12'd1600);
        run_pass("big");
        check("big_words", rx_cnt - base, 32'd0);
        check("big_dummy_read", dr_cnt - dbase, 32'd0);
        check("big_dropcnt", {24'd0, rxDropCnt}, 32'd2);

        // Reset in the middle of a burst
        base = rx_cnt;
        push_head(16'h0100);
        push_frame(16'h8000, 12'd64);
        recvEn = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk40m);
            if (rx_cnt - base >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        check("midrst_reached_word10", {31'd0, hit}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        accq.delete();
        rxq.delete();
        burstq.delete();
        recvEn = 1'b0;
        repeat (3) @(negedge clk40m);
        check("midrst_eof_held", {31'd0, rxEof}, 32'd0);
        reset = 1'b1;
        @(negedge clk40m);
        base = rx_cnt;
        push_acc(1'b0, 8'h92, 16'h0000, 16'h0000);
        run_pass("restart");
        check("restart_rxvalid", rx_cnt - base, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
